// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared definitions for the round-robin mux arbiter.
//   - DEFAULT_N / DEFAULT_W : default requester count and data width
//   - MAX_N / MAX_IDW       : largest supported requester count and its tag width
//   - pick_t                : result of a rotating-priority search (found flag + index)
//   - rr_pick()             : rotating-priority search over a request vector
package rr_arb_pkg;

  localparam int DEFAULT_N = 4;
  localparam int DEFAULT_W = 8;
  localparam int MAX_N     = 16;
  localparam int MAX_IDW   = 4;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } pick_t;

  // Returns the first set bit of req[0 +: n], scanning ptr, ptr+1, ..., n-1,
  // 0, ..., ptr-1. Bits at or above n are ignored. ptr must be below n.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                    input int unsigned      n,
                                    input int unsigned      ptr);
    pick_t       res;
    int unsigned pos;
    res.found = 1'b0;
    res.idx   = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        pos = ptr + k;
        if (pos >= n) pos = pos - n;
        if (!res.found && req[pos[MAX_IDW-1:0]]) begin
          res.found = 1'b1;
          res.idx   = pos[MAX_IDW-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational rotating-priority picker.
//   req   [N]   : request vector
//   ptr   [IDW] : index that has highest priority this cycle
//   grant [IDW] : index of the first request at or after ptr (wrapping)
//   found       : at least one request is set
module rr_priority_picker
  import rr_arb_pkg::*;
#(
  parameter int N   = DEFAULT_N,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] grant,
  output logic           found
);

  logic [MAX_N-1:0] req_ext;
  pick_t            pick;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_pick(req_ext, N, {{(32-IDW){1'b0}}, ptr});
    grant          = pick.idx[IDW-1:0];
    found          = pick.found;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter sharing one registered output channel
// among N valid/ready requesters.
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : [N]   requester i has a word
//   in_data    : [N*W] requester i data at bits [i*W +: W]
//   in_ready   : [N]   one-hot accept strobe for the granted requester
//   out_valid  : output register holds a word
//   out_data   : [W]   registered data of the granted requester
//   out_id     : [IDW] index of the requester that supplied out_data
//   out_ready  : consumer accepts out_data this cycle
//
// Handshake: a word moves on any edge where valid and ready are both high on
// the same side. Input side: in_ready[i] is high only for the granted index
// and only when the output register can take a word (empty, or draining this
// cycle), so the register may drain and refill on the same edge. Output side:
// while out_valid is high and out_ready low, out_data/out_id stay stable.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N   = DEFAULT_N,
  parameter int W   = DEFAULT_W,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [IDW-1:0]   out_id,
  input  logic             out_ready
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic           found;
  logic           load;
  logic           take;

  rr_priority_picker #(
    .N   (N),
    .IDW (IDW)
  ) u_picker (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (grant),
    .found (found)
  );

  assign load = !out_valid || out_ready;
  // Reset masks the accept strobe so no requester sees a handshake that the
  // register will not honour.
  assign take = load && found && !rst;

  always_comb begin
    in_ready = '0;
    if (take) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= in_data[grant*W +: W];
        out_id    <= grant;
        ptr       <= (grant == IDW'(N-1)) ? '0 : grant + IDW'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
